// File: rtl/event_gen.sv
// ============================================================================
// Module   : event_gen
// Brief    : Random future-event generator feeding a registered-output FIFO.
//            Optional gen_count statistics output under EVENT_GEN_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module event_gen #(
    parameter int unsigned TIME_W  = 16,
    parameter int unsigned LP_W    = 5,
    parameter int unsigned DELAY_W = 8,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [12:0]         rnd,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [TIME_W-1:0]   cur_time,
    input  logic [LP_W-1:0]     self_lp,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TIME_W-1:0]   out_time,
    output logic [LP_W-1:0]     out_lp
`ifdef EVENT_GEN_STATS_EN
    ,
    output logic [15:0]         gen_count
`endif
);

    localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);

    generate
        if (DELAY_W + LP_W != 13) begin : g_bad_split
            $error("event_gen: DELAY_W + LP_W must equal 13");
        end
        if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("event_gen: DEPTH must be a power of two");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TIME_W-1:0]   r_mem_time [DEPTH];
    logic [LP_W-1:0]     r_mem_lp   [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_out_valid;
    logic [TIME_W-1:0]   r_out_time;
    logic [LP_W-1:0]     r_out_lp;

    // ------------------------------------------------------------------
    // Event construction
    // ------------------------------------------------------------------
    logic [DELAY_W-1:0]  w_delay;
    logic [TIME_W:0]     w_sum;
    logic [TIME_W-1:0]   w_evt_time;
    logic [LP_W-1:0]     w_rnd_lp;
    logic [LP_W-1:0]     w_evt_lp;

    always_comb begin
        w_delay = rnd[DELAY_W-1:0];
        if (w_delay == '0) begin
            w_delay = DELAY_W'(1);
        end
    end

    // One extra bit of headroom exposes overflow for saturation.
    assign w_sum      = {1'b0, cur_time} + (TIME_W + 1)'(w_delay);
    assign w_evt_time = w_sum[TIME_W] ? {TIME_W{1'b1}} : w_sum[TIME_W-1:0];

    assign w_rnd_lp   = rnd[DELAY_W +: LP_W];
    assign w_evt_lp   = (w_rnd_lp == self_lp) ? (self_lp + LP_W'(1)) : w_rnd_lp;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [c_CNT_W-1:0]  w_count_after_pop;
    logic [c_CNT_W-1:0]  w_count_nxt;
    logic [c_PTR_W-1:0]  w_rd_ptr_nxt;

    assign w_full            = (r_count == c_CNT_W'(DEPTH));
    assign req_ready         = !w_full;
    assign w_push            = req_valid && !w_full;
    assign w_pop             = r_out_valid && out_ready;
    assign w_count_after_pop = r_count - c_CNT_W'(w_pop);
    assign w_count_nxt       = w_count_after_pop + c_CNT_W'(w_push);
    assign w_rd_ptr_nxt      = r_rd_ptr + c_PTR_W'(w_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_time  <= '0;
            r_out_lp    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem_time[i] <= '0;
                r_mem_lp[i]   <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_time[r_wr_ptr] <= w_evt_time;
                r_mem_lp[r_wr_ptr]   <= w_evt_lp;
                r_wr_ptr             <= r_wr_ptr + c_PTR_W'(1);
            end
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);

            // Head register preloads the next entry; when the queue drains to
            // nothing but the incoming event, bypass it straight to the head.
            if (w_count_nxt != '0) begin
                if (w_count_after_pop == '0) begin
                    r_out_time <= w_evt_time;
                    r_out_lp   <= w_evt_lp;
                end else begin
                    r_out_time <= r_mem_time[w_rd_ptr_nxt];
                    r_out_lp   <= r_mem_lp[w_rd_ptr_nxt];
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_time  = r_out_time;
    assign out_lp    = r_out_lp;

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef EVENT_GEN_STATS_EN
    logic [15:0] r_gen_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_gen_count <= '0;
        end else if (w_push) begin
            r_gen_count <= r_gen_count + 16'd1;
        end
    end

    assign gen_count = r_gen_count;
`else
    // Statistics disabled: no counter is built.
`endif

endmodule

`default_nettype wire

// File: tb/tb_event_gen.sv
// ============================================================================
// Module   : tb_event_gen
// Brief    : Directed self-checking bench for event_gen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_event_gen;

    logic        clk;
    logic        rst;
    logic [12:0] rnd;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] cur_time;
    logic [4:0]  self_lp;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_time;
    logic [4:0]  out_lp;
`ifdef EVENT_GEN_STATS_EN
    logic [15:0] gen_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    event_gen #(
        .TIME_W  (16),
        .LP_W    (5),
        .DELAY_W (8),
        .DEPTH   (4)
    ) u_dut (
        .clock     (clk),
        .reset     (rst),
        .rnd       (rnd),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .cur_time  (cur_time),
        .self_lp   (self_lp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_time  (out_time),
        .out_lp    (out_lp)
`ifdef EVENT_GEN_STATS_EN
        ,
        .gen_count (gen_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one request for exactly one rising edge.
    task automatic put(input logic [15:0] t, input logic [4:0] lp, input logic [12:0] r);
        cur_time  = t;
        self_lp   = lp;
        rnd       = r;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Push one event with out_ready high, check head, then check it was popped.
    task automatic single(input string tag, input logic [15:0] t, input logic [4:0] lp,
                          input logic [12:0] r, input logic [15:0] exp_t, input logic [4:0] exp_lp);
        out_ready = 1'b1;
        put(t, lp, r);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_time"},  32'(out_time),  32'(exp_t));
        chk({tag, "_lp"},    32'(out_lp),    32'(exp_lp));
        @(negedge clk);
        chk({tag, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] exp_t [4];
        logic [4:0]  exp_l [4];

        rst       = 1'b1;
        rnd       = '0;
        req_valid = 1'b0;
        cur_time  = '0;
        self_lp   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_time",  32'(out_time),  32'd0);
        chk("rst_lp",    32'(out_lp),    32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);

        // Basic push/pop, zero delay forcing, self-target bumping, saturation.
        single("basic",  16'd100,   5'd0,  13'h0105, 16'd105,   5'd1);
        single("zdelay", 16'd50,    5'd0,  13'h0300, 16'd51,    5'd3);
        single("self3",  16'd0,     5'd3,  13'h0310, 16'd16,    5'd4);
        single("self31", 16'd0,     5'd31, 13'h1F10, 16'd16,    5'd0);
        single("sat",    16'hFFF0,  5'd5,  13'h0020, 16'hFFFF,  5'd0);
        single("nosat",  16'hFFF0,  5'd5,  13'h0005, 16'hFFF5,  5'd0);
        single("maxdly", 16'd1000,  5'd2,  13'h02FF, 16'd1255,  5'd3);

        // Simultaneous push and pop on a non-empty queue.
        out_ready = 1'b0;
        put(16'd10, 5'd0, 13'h0401);
        chk("pp_headA", 32'(out_time), 32'd11);
        out_ready = 1'b1;
        put(16'd20, 5'd0, 13'h0502);
        chk("pp_valid", 32'(out_valid), 32'd1);
        chk("pp_headB", 32'(out_time),  32'd22);
        chk("pp_lpB",   32'(out_lp),    32'd5);
        @(negedge clk);
        chk("pp_empty", 32'(out_valid), 32'd0);

        // Fill to capacity with no consumer; fifth request must be refused.
`ifdef EVENT_GEN_STATS_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        out_ready = 1'b0;
        exp_t = '{16'd1001, 16'd1012, 16'd1023, 16'd1034};
        exp_l = '{5'd2, 5'd3, 5'd4, 5'd5};
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill_ready%0d", i), 32'(req_ready), (i < 4) ? 32'd1 : 32'd0);
            put(16'(1000 + 10 * i), 5'd0, 13'((256 * (i + 2)) + i + 1));
        end
        chk("fill_head", 32'(out_time), 32'(exp_t[0]));
        @(negedge clk);
        chk("hold_time", 32'(out_time), 32'(exp_t[0]));
        chk("hold_lp",   32'(out_lp),   32'(exp_l[0]));
`ifdef EVENT_GEN_STATS_EN
        chk("gen_count4", 32'(gen_count), 32'd4);
`endif
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain_valid%0d", j), 32'(out_valid), 32'd1);
            chk($sformatf("drain_time%0d", j),  32'(out_time),  32'(exp_t[j]));
            chk($sformatf("drain_lp%0d", j),    32'(out_lp),    32'(exp_l[j]));
            chk($sformatf("drain_ready%0d", j), 32'(req_ready), (j == 0) ? 32'd0 : 32'd1);
            @(negedge clk);
        end
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Reset mid-operation discards the queue and the concurrent request.
        out_ready = 1'b0;
        put(16'd1, 5'd0, 13'h0101);
        put(16'd2, 5'd0, 13'h0202);
        put(16'd3, 5'd0, 13'h0303);
        chk("q3_valid", 32'(out_valid), 32'd1);
        rst       = 1'b1;
        req_valid = 1'b1;
        rnd       = 13'h0404;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd1);
`ifdef EVENT_GEN_STATS_EN
        chk("mrst_count", 32'(gen_count), 32'd0);
`endif
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_none", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/event_gen.md
EVENT_GEN -- requirements
Module: event_gen

Interface
REQ-001 Parameter: TIME_W, default 16, event timestamp width.
REQ-002 Parameter: LP_W, default 5, logical-process ID width.
REQ-003 Parameter: DELAY_W, default 8, delay-offset width; the block SHALL require DELAY_W + LP_W = 13.
REQ-004 Parameter: DEPTH, default 4, output FIFO entries, power of two.
REQ-005 Port: clock  in  1  sole clock; all state on rising edge.
REQ-006 Port: reset  in  1  synchronous, active-high reset.
REQ-007 Port: rnd  in  13  pseudo-random word from the upstream LFSR stage, new value every cycle.
REQ-008 Port: req_valid  in  1  core requests one new event.
REQ-009 Port: req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-010 Port: cur_time  in  TIME_W  current simulation time of requesting LP.
REQ-011 Port: self_lp  in  LP_W  ID of requesting LP.
REQ-012 Port: out_valid  out  1  FIFO head holds an event.
REQ-013 Port: out_ready  in  1  downstream consumes head.
REQ-014 Port: out_time  out  TIME_W  head event timestamp.
REQ-015 Port: out_lp  out  LP_W  head event target LP.

Function
REQ-016 Accept (push) SHALL occur when req_valid && req_ready at a rising edge; rnd, cur_time, self_lp SHALL be sampled on that edge only.
REQ-017 req_ready SHALL equal !full, combinationally; no push when full, even with simultaneous pop.
REQ-018 delay = rnd[DELAY_W-1:0]; if delay = 0 it SHALL be forced to 1 (events strictly in the future).
REQ-019 Timestamp = cur_time + delay computed at TIME_W+1 bits, saturated to all-ones on overflow.
REQ-020 Target = rnd[12:DELAY_W]; if target = self_lp, target SHALL be self_lp + 1 modulo 2^LP_W.
REQ-021 Pushed event SHALL be visible on out_valid/out_time/out_lp the cycle after accept (1-cycle latency when empty).
REQ-022 Pop SHALL occur when out_valid && out_ready; out_time/out_lp SHALL hold stable while out_valid && !out_ready.
REQ-023 Simultaneous push and pop when neither full nor empty SHALL leave occupancy unchanged; pop of an empty FIFO SHALL be ignored.
REQ-024 Events SHALL leave in acceptance order; read/write pointers SHALL wrap modulo DEPTH with an occupancy counter 0..DEPTH distinguishing full from empty.
REQ-025 Output values SHALL be registered; out_* while out_valid = 0 are don't-care but SHALL not be X after reset.

Reset
REQ-026 On reset: occupancy 0, pointers 0, out_valid 0, out_time 0, out_lp 0; req_ready 1 from the first cycle after reset deasserts.
REQ-027 A request presented in a reset cycle SHALL be dropped; reset mid-operation SHALL discard all queued events.

Configuration
REQ-028 Macro EVENT_GEN_STATS_EN defined: extra output gen_count (16 bits) SHALL count accepted requests, wrap 0xFFFF->0, reset to 0.
REQ-029 Macro EVENT_GEN_STATS_EN undefined: gen_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 cur_time=100, self_lp=0, rnd=13'h0105, push, out_ready=1 -> next cycle out_valid=1, out_time=105, out_lp=1; popped, FIFO empty.
REQ-031 rnd=13'h0300, cur_time=50, self_lp=0 -> out_time=51 (zero delay forced to 1), out_lp=3.
REQ-032 rnd=13'h0310, self_lp=3, cur_time=0 -> out_lp=4, out_time=16; also rnd=13'h1F10, self_lp=31 -> out_lp=0.
REQ-033 cur_time=16'hFFF0, rnd=13'h0020 -> out_time=16'hFFFF (saturated).
REQ-034 out_ready=0, 5 back-to-back requests -> req_ready low after 4th; 5th not accepted; then out_ready=1 -> 4 events drained in order, req_ready returns high after first pop; gen_count=4 with EVENT_GEN_STATS_EN.
REQ-035 Queue 3 events, assert reset 1 cycle with req_valid=1 -> out_valid=0 next cycle, nothing emitted, gen_count=0.
